spiflash_reader: RTL
====================

Name: spiflash_reader

Overview:
- SPI flash read master: the upstream stage that drives the spiflash emulator's csb/spiclk/io0 pins and collects io1.
- Accepts a (24-bit byte address, word count) request and issues a standard READ (0x03) command plus the 24-bit address, MSB first.
- Streams the returned bytes out as 32-bit little-endian words over a valid/ready interface.
- Sits between the boot/fetch logic and the flash pins, on the ap_clk domain.

Parameters:
CLK_DIV, 2, spiclk half-period in ap_clk cycles (>=1); 2 gives spiclk = ap_clk/4
LEN_W, 8, width of the word-count field
CS_IDLE, 2, ap_clk cycles csb held high after a transaction before done/ready

Ports:
ap_clk  in  1  clock
ap_rst  in  1  asynchronous active-low reset
req_valid  in  1  request strobe
req_ready  out  1  request accepted when req_valid&&req_ready at rising ap_clk
req_addr  in  24  flash byte address
req_words  in  LEN_W  number of 32-bit words to read
rd_data  out  32  read word; first byte received in [7:0], fourth in [31:24]
rd_valid  out  1  rd_data valid, held until rd_ready
rd_ready  in  1  consumer ready
busy  out  1  transaction in progress
done  out  1  one-cycle pulse at end of transaction
csb  out  1  flash chip select, active low
spiclk  out  1  SPI clock, mode 0 (idles low)
io0  out  1  MOSI
io1  in  1  MISO

Behaviour:
- Reset (ap_rst=0, asynchronous): csb=1, spiclk=0, io0=0, rd_valid=0, rd_data=0, busy=0, done=0, req_ready=0. In-flight data is discarded.
- req_ready rises at the first ap_clk edge after reset release and is 1 only in IDLE. req_valid is ignored whenever req_ready=0.
- FSM: IDLE -> SETUP -> SHIFT_CMD (32 bits: 0x03, addr[23:0]) -> SHIFT_DATA (32*req_words bits) -> HOLD -> IDLE.
- Accept at edge t0: addr and count are latched; req_ready=0 and busy=1. From t0+1: csb=0 and io0 = first command bit.
- SETUP holds spiclk low for CLK_DIV cycles. The first spiclk rise is at t0+1+CLK_DIV.
- Mode 0 timing:
  - Rising spiclk edge: io1 is sampled in SHIFT_DATA.
  - Falling spiclk edge: io0 is updated to the next bit.
  - Each level lasts CLK_DIV ap_clk cycles.
  - io0=0 throughout SHIFT_DATA.
- Bytes are received MSB first and packed little-endian into a 32-bit shift register.
- Word completion: at the falling edge after a word's 32nd rise, the word moves to the output register if rd_valid=0 or rd_ready=1 in that cycle. rd_valid is asserted next cycle.
  - The first word becomes valid at t0+1+128*CLK_DIV (t0+257 for CLK_DIV=2).
- Stall: if the output register is still occupied at word completion, the divider freezes with spiclk=0 and csb=0 until the transfer happens. No bits are lost, and no spiclk edges occur while stalled.
- rd_data stays stable while rd_valid=1 and rd_ready=0.
- Simultaneous rd_ready and word completion: the old word is consumed and the new one loaded in the same cycle, with no stall.
- The last word goes through the same transfer rule. Once it is transferred: HOLD with csb=1 and spiclk=0 for CS_IDLE cycles, then a done pulse and busy=0 with req_ready=1 in the same cycle. The final rd_valid may still be pending at that point.
- req_words=0: accepted, csb stays high, no spiclk edges, done pulses at t0+1.
- The address is not range-checked. The flash handles auto-increment and any wrap past 0xFFFFFF.
- Bit counter: 6-bit per word for the command/address phase, plus an LEN_W-bit word counter.

Decomposition:
- Package spiflash_pkg:
  - SPI_CMD_READ = 8'h03
  - SPI_ADDR_W = 24
  - FSM state enum (IDLE, SETUP, SHIFT_CMD, SHIFT_DATA, HOLD)
- Sub-module spi_clkgen: CLK_DIV divider with enable/freeze input; outputs spiclk plus single-cycle rise_stb/fall_stb strobes.

Test Plan:
- Reset: hold ap_rst=0 mid-clock -> csb=1, spiclk=0, io0=0, rd_valid=0, busy=0, req_ready=0 immediately; req_ready=1 one edge after release.
- Single word: BRAM word0=32'h12345678, request addr 0x000000, words=1, CLK_DIV=2 -> io0 carries 0x03,0x00,0x00,0x00; rd_data=32'h12345678 valid at t0+257; exactly 64 spiclk rises; done one cycle after HOLD.
- Burst: addr 0x000020, words=5, rd_ready=1 -> rd_data equals BRAM words 8..12 in order; 192 spiclk rises; csb low continuously; no stall gaps.
- Backpressure: words=3, rd_ready=0 for 300 cycles after first rd_valid -> spiclk frozen low after rise #96, csb stays 0, rd_data unchanged; after rd_ready=1 all 3 words are correct and the total is 128 rises.
- Reset mid-SHIFT_DATA (after rise #40) -> csb=1 and rd_valid=0 asynchronously; a subsequent addr 0x000020 words=1 request returns BRAM word 8.
- Edge requests: words=0 -> no csb/spiclk activity, done at t0+1; req_valid pulsed while busy -> ignored, no second transaction.

Source files
------------

// File: rtl/spiflash_pkg.sv
// Shared definitions for the SPI flash read master: command constants,
// controller state encoding and the byte-order helper for returned words.
package spiflash_pkg;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam int         SPI_ADDR_W    = 24;
    // Rises per 32-bit unit (command+address phase, or one data word).
    localparam logic [5:0] BITS_PER_UNIT = 6'd32;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_CMD,
        SHIFT_DATA,
        HOLD
    } state_e;

    // Bytes arrive MSB first into a left-shifting register; the first byte
    // received must land in [7:0] of the delivered word.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SPI mode-0 clock divider: toggles spiclk every CLK_DIV enabled ap_clk cycles
// and flags the ap_clk edge on which each spiclk rise or fall lands.
module spi_clkgen #(
    parameter int CLK_DIV = 2
) (
    input  logic ap_clk,
    input  logic ap_rst,
    input  logic en_i,
    input  logic clr_i,
    output logic spiclk_o,
    output logic rise_stb_o,
    output logic fall_stb_o
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             term;

    assign term = (cnt_q == CNT_W'(CLK_DIV - 1));

    // NOTE: every output of this block gets a default first, so no path
    // through the if/else can leave a value unassigned and infer a latch.
    always_comb begin
        cnt_d      = cnt_q;
        sclk_d     = sclk_q;
        rise_stb_o = 1'b0;
        fall_stb_o = 1'b0;
        if (clr_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (en_i) begin
            if (term) begin
                cnt_d      = '0;
                sclk_d     = ~sclk_q;
                rise_stb_o = ~sclk_q;
                fall_stb_o = sclk_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of block evaluation order.
    always_ff @(posedge ap_clk or negedge ap_rst) begin
        if (!ap_rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign spiclk_o = sclk_q;

endmodule

// File: rtl/spiflash_reader.sv
// SPI flash READ (0x03) master: sends command plus 24-bit address, then streams
// the returned bytes out as little-endian 32-bit words over valid/ready.
module spiflash_reader
    import spiflash_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = 8,
    parameter int CS_IDLE = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SPI_ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]      req_words,
    output logic [31:0]           rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  csb,
    output logic                  spiclk,
    output logic                  io0,
    input  logic                  io1
);

    localparam int HCNT_W = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

    state_e            state_q, state_d;
    logic [31:0]       cmd_sr_q, cmd_sr_d;
    logic [31:0]       rx_sr_q, rx_sr_d;
    logic [LEN_W-1:0]  words_left_q, words_left_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic [HCNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              pend_q, pend_d;
    logic              csb_q, csb_d;
    logic              io0_q, io0_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              req_ready_q, req_ready_d;

    logic rise_stb, fall_stb;
    logic accept, out_free, word_done;

    // The divider runs only while csb is low and no finished word is waiting
    // for the output register; a waiting word freezes spiclk low.
    spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .en_i       (!csb_q && !pend_q),
        .clr_i      (csb_q),
        .spiclk_o   (spiclk),
        .rise_stb_o (rise_stb),
        .fall_stb_o (fall_stb)
    );

    assign accept    = (state_q == IDLE) && req_ready_q && req_valid;
    assign out_free  = !rd_valid_q || rd_ready;
    assign word_done = (state_q == SHIFT_DATA) &&
                       (pend_q || (fall_stb && bit_cnt_q == BITS_PER_UNIT));

    always_comb begin
        state_d      = state_q;
        cmd_sr_d     = cmd_sr_q;
        rx_sr_d      = rx_sr_q;
        words_left_d = words_left_q;
        bit_cnt_d    = bit_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        pend_d       = pend_q;
        csb_d        = csb_q;
        io0_d        = io0_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = rd_valid_q;
        done_d       = 1'b0;

        if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = SETUP;
                    cmd_sr_d     = {SPI_CMD_READ, req_addr};
                    words_left_d = req_words;
                    bit_cnt_d    = '0;
                    pend_d       = 1'b0;
                end
            end
            SETUP: begin
                if (csb_q) begin
                    // A zero-length request finishes without touching the bus.
                    if (words_left_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        csb_d = 1'b0;
                        io0_d = cmd_sr_q[31];
                    end
                end else if (rise_stb) begin
                    state_d   = SHIFT_CMD;
                    bit_cnt_d = 6'd1;
                end
            end
            SHIFT_CMD: begin
                if (rise_stb) begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end else if (fall_stb) begin
                    if (bit_cnt_q == BITS_PER_UNIT) begin
                        state_d   = SHIFT_DATA;
                        bit_cnt_d = '0;
                        io0_d     = 1'b0;
                    end else begin
                        cmd_sr_d = {cmd_sr_q[30:0], 1'b0};
                        io0_d    = cmd_sr_q[30];
                    end
                end
            end
            SHIFT_DATA: begin
                if (rise_stb) begin
                    rx_sr_d   = {rx_sr_q[30:0], io1};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end
                if (word_done) begin
                    if (out_free) begin
                        rd_data_d  = bswap32(rx_sr_q);
                        rd_valid_d = 1'b1;
                        pend_d     = 1'b0;
                        bit_cnt_d  = '0;
                        if (words_left_q == LEN_W'(1)) begin
                            state_d    = HOLD;
                            csb_d      = 1'b1;
                            hold_cnt_d = '0;
                        end else begin
                            words_left_d = words_left_q - LEN_W'(1);
                        end
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (hold_cnt_q == HCNT_W'(CS_IDLE - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HCNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                csb_d   = 1'b1;
            end
        endcase

        busy_d      = (state_d != IDLE);
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge ap_clk or negedge ap_rst) begin
        if (!ap_rst) begin
            state_q      <= IDLE;
            cmd_sr_q     <= '0;
            rx_sr_q      <= '0;
            words_left_q <= '0;
            bit_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            pend_q       <= 1'b0;
            csb_q        <= 1'b1;
            io0_q        <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            req_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_sr_q     <= cmd_sr_d;
            rx_sr_q      <= rx_sr_d;
            words_left_q <= words_left_d;
            bit_cnt_q    <= bit_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            pend_q       <= pend_d;
            csb_q        <= csb_d;
            io0_q        <= io0_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign csb       = csb_q;
    assign io0       = io0_q;

endmodule
